bip_uart_loader: RTL and testbench

Host-to-processor side of the BIP debug link. Consumes bytes delivered by the UART receiver, decodes a small command protocol, writes received 16-bit instruction words into BIP instruction memory, and gates BIP execution (run / single-step / halt). It sits between the UART RX and the BIP's instruction-memory write port and enable input. It is the inbound counterpart of the interface that streams acc/instruction/clock-count records out over UART TX.

---
 rtl/bip_uart_loader_if.sv | 30 +++
 rtl/bip_uart_loader.sv | 192 +++++++++++++++++++
 tb/tb_bip_uart_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_uart_loader_if.sv
// Inbound BIP debug-link bundle: UART RX byte stream in, instruction-memory
// write port and BIP run control out. The loader uses the master view,
// the surrounding logic (UART RX, BIP core) uses the slave view.
interface bip_uart_loader_if #(
   parameter int NB_DATA            = 16,
   parameter int NB_BYTE            = 8,
   parameter int LOG2_N_INSMEM_ADDR = 4
);
   logic [NB_BYTE-1:0]            i_rx_data;
   logic                          i_rx_done;
   logic                          o_wr_en;
   logic [LOG2_N_INSMEM_ADDR-1:0] o_wr_addr;
   logic [NB_DATA-1:0]            o_wr_data;
   logic                          o_bip_enable;
   logic                          o_bip_reset;
   logic                          o_busy;
   logic                          o_error;

   modport master (
      input  i_rx_data, i_rx_done,
      output o_wr_en, o_wr_addr, o_wr_data,
      output o_bip_enable, o_bip_reset, o_busy, o_error
   );

   modport slave (
      output i_rx_data, i_rx_done,
      input  o_wr_en, o_wr_addr, o_wr_data,
      input  o_bip_enable, o_bip_reset, o_busy, o_error
   );
endinterface

// File: rtl/bip_uart_loader.sv
// Host-to-BIP debug loader: decodes UART command bytes, writes 16-bit
// instruction words into BIP instruction memory and gates BIP execution.
// Every output is a flop; the next-state logic computes each output's next
// value from the next state so outputs line up with the state they describe.
module bip_uart_loader #(
   parameter int NB_DATA            = 16,
   parameter int NB_BYTE            = 8,
   parameter int LOG2_N_INSMEM_ADDR = 4
) (
   input  logic                i_clock,
   input  logic                i_reset,
   bip_uart_loader_if.master   bus
);

   localparam int N_INSMEM = 2 ** LOG2_N_INSMEM_ADDR;
   // One extra bit so a full-memory count (N_INSMEM) fits.
   localparam int CNT_W    = LOG2_N_INSMEM_ADDR + 1;

   localparam logic [NB_BYTE-1:0] CMD_LOAD      = NB_BYTE'(8'h01);
   localparam logic [NB_BYTE-1:0] CMD_RUN       = NB_BYTE'(8'h02);
   localparam logic [NB_BYTE-1:0] CMD_STEP      = NB_BYTE'(8'h03);
   localparam logic [NB_BYTE-1:0] CMD_BIP_RESET = NB_BYTE'(8'h04);
   localparam logic [NB_BYTE-1:0] CMD_HALT      = NB_BYTE'(8'h05);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_COUNT,
      ST_GET_HI,
      ST_GET_LO,
      ST_WRITE,
      ST_RUN
   } state_e;

   // Load phases hold the BIP in reset so it restarts at PC 0 afterwards.
   function automatic logic is_load(input state_e s);
      return (s == ST_GET_COUNT) || (s == ST_GET_HI) ||
             (s == ST_GET_LO)    || (s == ST_WRITE);
   endfunction

   state_e                        state_q,      state_d;
   logic                          rx_done_q;
   logic [CNT_W-1:0]              count_q,      count_d;
   logic [CNT_W-1:0]              addr_q,       addr_d;
   logic [NB_BYTE-1:0]            hi_q,         hi_d;
   logic                          wr_en_q,      wr_en_d;
   logic [LOG2_N_INSMEM_ADDR-1:0] wr_addr_q,    wr_addr_d;
   logic [NB_DATA-1:0]            wr_data_q,    wr_data_d;
   logic                          bip_enable_q, bip_enable_d;
   logic                          bip_reset_q,  bip_reset_d;
   logic                          busy_q,       busy_d;
   logic                          error_q,      error_d;
   logic                          step_req;
   logic                          reset_req;
   logic                          rx_pos;

   // A byte is consumed only on the rising edge of rx_done, so a held level
   // delivers exactly one byte.
   assign rx_pos = bus.i_rx_done & ~rx_done_q;

   // Next-state, datapath and registered-output next values.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can leave
      // it unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      count_d     = count_q;
      addr_d      = addr_q;
      hi_d        = hi_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      error_d     = error_q;
      step_req    = 1'b0;
      reset_req   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_pos) begin
               // Any valid command clears a pending error.
               error_d = 1'b0;
               case (bus.i_rx_data)
                  CMD_LOAD:      state_d   = ST_GET_COUNT;
                  CMD_RUN:       state_d   = ST_RUN;
                  CMD_STEP:      step_req  = 1'b1;
                  CMD_BIP_RESET: reset_req = 1'b1;
                  default:       error_d   = 1'b1;
               endcase
            end
         end

         ST_GET_COUNT: begin
            if (rx_pos) begin
               if (bus.i_rx_data == '0) begin
                  state_d = ST_IDLE;
               end else if (int'(bus.i_rx_data) > N_INSMEM) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  count_d = bus.i_rx_data[CNT_W-1:0];
                  addr_d  = '0;
                  state_d = ST_GET_HI;
               end
            end
         end

         ST_GET_HI: begin
            if (rx_pos) begin
               hi_d    = bus.i_rx_data;
               state_d = ST_GET_LO;
            end
         end

         ST_GET_LO: begin
            // The write strobe is issued from here so it is visible in the
            // single WRITE cycle that follows.
            if (rx_pos) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q[LOG2_N_INSMEM_ADDR-1:0];
               wr_data_d = {hi_q, bus.i_rx_data};
               state_d   = ST_WRITE;
            end
         end

         ST_WRITE: begin
            // A byte arriving here cannot be buffered; flag it and finish.
            if (rx_pos) begin
               error_d = 1'b1;
            end
            addr_d = addr_q + CNT_W'(1);
            if (addr_d < count_q) begin
               state_d = ST_GET_HI;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            if (rx_pos && (bus.i_rx_data == CMD_HALT)) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // is_load(state_q) also covers the first IDLE cycle after any load exit.
      bip_reset_d  = is_load(state_d) | is_load(state_q) | reset_req;
      bip_enable_d = (state_d == ST_RUN) | step_req;
      busy_d       = (state_d != ST_IDLE);
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge i_clock) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      if (!i_reset) begin
         state_q      <= ST_IDLE;
         rx_done_q    <= 1'b0;
         count_q      <= '0;
         addr_q       <= '0;
         hi_q         <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         bip_enable_q <= 1'b0;
         bip_reset_q  <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_done_q    <= bus.i_rx_done;
         count_q      <= count_d;
         addr_q       <= addr_d;
         hi_q         <= hi_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         bip_enable_q <= bip_enable_d;
         bip_reset_q  <= bip_reset_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
      end
   end

   assign bus.o_wr_en      = wr_en_q;
   assign bus.o_wr_addr    = wr_addr_q;
   assign bus.o_wr_data    = wr_data_q;
   assign bus.o_bip_enable = bip_enable_q;
   assign bus.o_bip_reset  = bip_reset_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_error      = error_q;

endmodule

// File: tb/tb_bip_uart_loader.sv
// Self-checking bench for bip_uart_loader. Expected memory writes are queued
// as load bytes are driven and compared when the DUT strobes o_wr_en.
module tb_bip_uart_loader;

   localparam int NB_DATA = 16;
   localparam int NB_BYTE = 8;
   localparam int LOG2    = 4;

   typedef struct {
      logic [LOG2-1:0]    addr;
      logic [NB_DATA-1:0] data;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   wr_t  exp_q[$];
   wr_t  exp_e;
   int   errors   = 0;
   int   checks   = 0;
   int   wr_count = 0;
   logic wr_prev  = 1'b0;

   bip_uart_loader_if #(
      .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .LOG2_N_INSMEM_ADDR(LOG2)
   ) bus ();

   bip_uart_loader #(
      .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .LOG2_N_INSMEM_ADDR(LOG2)
   ) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_bip_enable,
                  bus.o_bip_reset, bus.o_busy, bus.o_error});
   endfunction

   // One byte: rx_done rises at a negedge, the DUT sees rx_pos at the next
   // posedge (cycle k), and the task returns at the following negedge where
   // the k+1 outputs are stable.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.i_rx_data = b;
      bus.i_rx_done = 1'b1;
      @(negedge clk);
      bus.i_rx_done = 1'b0;
   endtask

   task automatic push_wr(input int addr, input logic [15:0] data);
      wr_t e;
      e.addr = LOG2'(addr);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Write monitor: every strobe is single-cycle and matches the scoreboard.
   always @(negedge clk) begin
      if (bus.o_wr_en === 1'b1) begin
         wr_count++;
         check("wr_single_cycle", 32'(wr_prev), 32'd0);
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check("wr_addr", 32'(bus.o_wr_addr), 32'(exp_e.addr));
            check("wr_data", 32'(bus.o_wr_data), 32'(exp_e.data));
         end
      end
      wr_prev = (bus.o_wr_en === 1'b1);
   end

   // Watchdog: the stimulus is fixed-length, this only guards against a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  ld3 [6];
      logic [15:0] w;
      int          en_sum;

      bus.i_rx_data = '0;
      bus.i_rx_done = 1'b0;
      ld3[0] = 8'h12; ld3[1] = 8'h34; ld3[2] = 8'hAB;
      ld3[3] = 8'hCD; ld3[4] = 8'h00; ld3[5] = 8'h07;

      // Reset hold with rx_done toggling.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.i_rx_data = 8'h01;
         bus.i_rx_done = ~bus.i_rx_done;
         check("rst_hold_outs", outs(), 32'd0);
      end
      @(negedge clk);
      bus.i_rx_done = 1'b0;
      rst_n         = 1'b1;
      idle(2);
      check("rst_release_outs", outs(), 32'd0);
      check("rst_no_writes", 32'(wr_count), 32'd0);

      // Load three words.
      push_wr(0, 16'h1234);
      push_wr(1, 16'hABCD);
      push_wr(2, 16'h0007);
      send_byte(8'h01);
      check("ld_busy", 32'(bus.o_busy), 32'd1);
      check("ld_bip_reset", 32'(bus.o_bip_reset), 32'd1);
      send_byte(8'h03);
      check("ld_bip_reset", 32'(bus.o_bip_reset), 32'd1);
      for (int i = 0; i < 6; i++) begin
         send_byte(ld3[i]);
         check("ld_bip_reset", 32'(bus.o_bip_reset), 32'd1);
      end
      check("ld_last_wr_en", 32'(bus.o_wr_en), 32'd1);
      @(negedge clk);
      check("ld_tail_reset", 32'(bus.o_bip_reset), 32'd1);
      check("ld_idle_busy", 32'(bus.o_busy), 32'd0);
      @(negedge clk);
      check("ld_reset_end", 32'(bus.o_bip_reset), 32'd0);
      check("ld_wr_count", 32'(wr_count), 32'd3);
      check("ld_hold_addr", 32'(bus.o_wr_addr), 32'd2);
      check("ld_hold_data", 32'(bus.o_wr_data), 32'h0007);

      // Full memory: 16 words, addresses 0..15.
      send_byte(8'h01);
      send_byte(8'h10);
      for (int i = 0; i < 16; i++) begin
         w = 16'(i * 16'h1111) ^ 16'h5A3C;
         push_wr(i, w);
         send_byte(w[15:8]);
         send_byte(w[7:0]);
      end
      idle(3);
      check("full_wr_count", 32'(wr_count), 32'd19);
      check("full_sb_empty", 32'(exp_q.size()), 32'd0);
      check("full_busy", 32'(bus.o_busy), 32'd0);
      check("full_last_addr", 32'(bus.o_wr_addr), 32'd15);

      // Oversize count.
      send_byte(8'h01);
      send_byte(8'h11);
      check("over_error", 32'(bus.o_error), 32'd1);
      check("over_busy", 32'(bus.o_busy), 32'd0);
      check("over_tail_reset", 32'(bus.o_bip_reset), 32'd1);
      idle(2);
      check("over_no_writes", 32'(wr_count), 32'd19);

      // Run / ignored byte / halt / step.
      send_byte(8'h02);
      check("run_clears_error", 32'(bus.o_error), 32'd0);
      check("run_enable", 32'(bus.o_bip_enable), 32'd1);
      idle(3);
      check("run_enable_held", 32'(bus.o_bip_enable), 32'd1);
      send_byte(8'h07);
      check("run_ignore_error", 32'(bus.o_error), 32'd0);
      check("run_ignore_enable", 32'(bus.o_bip_enable), 32'd1);
      check("run_busy", 32'(bus.o_busy), 32'd1);
      send_byte(8'h05);
      check("halt_enable", 32'(bus.o_bip_enable), 32'd0);
      check("halt_busy", 32'(bus.o_busy), 32'd0);
      send_byte(8'h03);
      check("step_enable_hi", 32'(bus.o_bip_enable), 32'd1);
      @(negedge clk);
      check("step_enable_lo", 32'(bus.o_bip_enable), 32'd0);

      // Bad command.
      send_byte(8'h09);
      check("bad_cmd_error", 32'(bus.o_error), 32'd1);
      check("bad_cmd_busy", 32'(bus.o_busy), 32'd0);

      // Held-high rx_done carrying RUN.
      @(negedge clk);
      bus.i_rx_data = 8'h02;
      bus.i_rx_done = 1'b1;
      @(negedge clk);
      check("held_run_enable", 32'(bus.o_bip_enable), 32'd1);
      check("held_run_error", 32'(bus.o_error), 32'd0);
      idle(9);
      bus.i_rx_done = 1'b0;
      send_byte(8'h05);
      check("held_halt", 32'(bus.o_bip_enable), 32'd0);

      // Held-high rx_done carrying STEP: exactly one enable cycle.
      @(negedge clk);
      bus.i_rx_data = 8'h03;
      bus.i_rx_done = 1'b1;
      en_sum = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         en_sum += int'(bus.o_bip_enable);
      end
      bus.i_rx_done = 1'b0;
      check("held_step_cycles", 32'(en_sum), 32'd1);
      idle(2);

      // Reset in the middle of a load.
      push_wr(0, 16'h1122);
      send_byte(8'h01);
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      @(negedge clk);
      rst_n = 1'b0;
      idle(2);
      check("midrst_outs", outs(), 32'd0);
      rst_n = 1'b1;
      idle(1);
      check("midrst_release_outs", outs(), 32'd0);
      check("midrst_wr_count", 32'(wr_count), 32'd20);
      check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
      send_byte(8'h04);
      check("bipreset_pulse_hi", 32'(bus.o_bip_reset), 32'd1);
      check("bipreset_busy", 32'(bus.o_busy), 32'd0);
      @(negedge clk);
      check("bipreset_pulse_lo", 32'(bus.o_bip_reset), 32'd0);
      idle(2);
      check("final_wr_count", 32'(wr_count), 32'd20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
